// File: rtl/slave_reg_arbiter.sv
// -----------------------------------------------------------------------------
// slave_reg_arbiter
//   Two-master arbiter in front of the single register port of the threshold
//   register block. Master 0 is the host CPU bridge, master 1 the
//   init/calibration sequencer. Each access is latched at grant, issued as a
//   one-cycle slave strobe, waits out the slave read latency (RD_LAT cycles)
//   and is completed with a one-cycle ack to the granted master.
//   Per-access timing: IDLE (T) -> ACCESS (T+1) -> WAIT x RD_LAT -> ACK.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined  : fixed priority, m0 wins ties, no RR pointer
//                      undefined: round-robin between the two masters
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req/wr/addr/wrdata     master N request (level, held until mN_ack)
//   mN_ack                    one-cycle completion pulse
//   mN_rddata                 last read result of master N
//   slave_addr/wr/rd/wrdata   register block access port
//   slave_rddata              register block read data (RD_LAT after strobe)
//   grant                     one-hot current owner, 00 when idle
//   busy                      high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module slave_reg_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wrdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rddata,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wrdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rddata,

    output logic [ADDR_W-1:0] slave_addr,
    output logic              slave_wr,
    output logic              slave_rd,
    output logic [DATA_W-1:0] slave_wrdata,
    input  logic [DATA_W-1:0] slave_rddata,

    output logic [1:0]        grant,
    output logic              busy
);

    // RD_LAT is legal in 1..4, so a 3-bit down-counter is enough.
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;          // latched direction of current access
    logic              owner_q, owner_d;    // 0 = m0, 1 = m1

    logic [ADDR_W-1:0] slave_addr_d;
    logic [DATA_W-1:0] slave_wrdata_d;
    logic              slave_wr_d, slave_rd_d;
    logic [1:0]        grant_d;
    logic              busy_d;
    logic              m0_ack_d, m1_ack_d;
    logic [DATA_W-1:0] m0_rddata_d, m1_rddata_d;

    logic              any_req;
    logic              pick_m1;             // arbitration winner when any_req

    assign any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: m1 only wins when m0 is not asking.
    assign pick_m1 = ~m0_req;
`else
    // Round-robin pointer: 1 means m1 is preferred on the next tie.
    logic prio_m1_q, prio_m1_d;

    assign pick_m1 = m1_req & (~m0_req | prio_m1_q);

    // Pointer moves away from whoever is granted, on every grant.
    always_comb begin
        prio_m1_d = prio_m1_q;
        if (state_q == IDLE && any_req) begin
            prio_m1_d = ~pick_m1;
        end
    end

    // Reset favours m0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_m1_q <= 1'b0;
        end else begin
            prio_m1_q <= prio_m1_d;
        end
    end
`endif

    // Next-state and next-output logic; all outputs are registered.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wr_d           = wr_q;
        owner_d        = owner_q;
        slave_addr_d   = slave_addr;
        slave_wrdata_d = slave_wrdata;
        slave_wr_d     = 1'b0;
        slave_rd_d     = 1'b0;
        grant_d        = grant;
        m0_ack_d       = 1'b0;
        m1_ack_d       = 1'b0;
        m0_rddata_d    = m0_rddata;
        m1_rddata_d    = m1_rddata;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    // Latch the winner's request; master changes after this are ignored.
                    owner_d        = pick_m1;
                    wr_d           = pick_m1 ? m1_wr     : m0_wr;
                    slave_addr_d   = pick_m1 ? m1_addr   : m0_addr;
                    slave_wrdata_d = pick_m1 ? m1_wrdata : m0_wrdata;
                    slave_wr_d     = wr_d;
                    slave_rd_d     = ~wr_d;
                    grant_d        = pick_m1 ? 2'b10 : 2'b01;
                    state_d        = ACCESS;
                end
            end

            ACCESS: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end

            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    // Read data is only valid in the last wait cycle.
                    if (!wr_q) begin
                        if (owner_q) begin
                            m1_rddata_d = slave_rddata;
                        end else begin
                            m0_rddata_d = slave_rddata;
                        end
                    end
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_LAST;
                end
            end

            ACK: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            owner_q      <= 1'b0;
            slave_addr   <= '0;
            slave_wrdata <= '0;
            slave_wr     <= 1'b0;
            slave_rd     <= 1'b0;
            grant        <= 2'b00;
            busy         <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rddata    <= '0;
            m1_rddata    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            owner_q      <= owner_d;
            slave_addr   <= slave_addr_d;
            slave_wrdata <= slave_wrdata_d;
            slave_wr     <= slave_wr_d;
            slave_rd     <= slave_rd_d;
            grant        <= grant_d;
            busy         <= busy_d;
            m0_ack       <= m0_ack_d;
            m1_ack       <= m1_ack_d;
            m0_rddata    <= m0_rddata_d;
            m1_rddata    <= m1_rddata_d;
        end
    end

endmodule
